maze_mem_arbiter: RTL

Shares the single-port maze bitmap memory between the rat solver controller and a host port used for maze load and readback. Grants at most one access per cycle, drives the memory command, and returns read data to the owning requester with fixed latency. Sits between the solver controller/host interface and the maze memory, and replaces the current direct solver-to-memory wiring.

---
 rtl/maze_pkg.sv | 17 +
 rtl/maze_mem_arbiter_if.sv | 31 +++
 rtl/maze_rd_return.sv | 47 ++++
 rtl/maze_mem_arbiter.sv | 103 ++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared types for the maze memory arbiter: owner encoding and read-return tag.
package maze_pkg;

    localparam int COORD_W_DEF = 4;
    localparam int STARVE_W    = 4;

    typedef enum logic {
        OWN_SOLVER = 1'b0,
        OWN_HOST   = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } rd_tag_t;

endpackage

// File: rtl/maze_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the maze bitmap memory.
// Handshake: a requester raises req with we/x/y/wdata stable and holds them until gnt;
// gnt is combinational and the access completes in the cycle where req && gnt.
interface maze_mem_arbiter_if #(parameter int COORD_W = maze_pkg::COORD_W_DEF);

    logic               s_req, s_we, s_wdata, s_gnt, s_rvalid, s_rdata;
    logic [COORD_W-1:0] s_x, s_y;
    logic               h_req, h_we, h_wdata, h_gnt, h_rvalid, h_rdata;
    logic [COORD_W-1:0] h_x, h_y;
    logic [COORD_W-1:0] mem_x, mem_y;
    logic               mem_rd, mem_wr, mem_din, mem_dout;

    modport slave (
        input  s_req, s_we, s_x, s_y, s_wdata,
        output s_gnt, s_rvalid, s_rdata,
        input  h_req, h_we, h_x, h_y, h_wdata,
        output h_gnt, h_rvalid, h_rdata,
        output mem_x, mem_y, mem_rd, mem_wr, mem_din,
        input  mem_dout
    );

    modport master (
        output s_req, s_we, s_x, s_y, s_wdata,
        input  s_gnt, s_rvalid, s_rdata,
        output h_req, h_we, h_x, h_y, h_wdata,
        input  h_gnt, h_rvalid, h_rdata,
        input  mem_x, mem_y, mem_rd, mem_wr, mem_din,
        output mem_dout
    );

endinterface

// File: rtl/maze_rd_return.sv
// Two-stage read tag pipeline: captures mem_dout for the owning port one cycle
// after the grant and pulses that port's rvalid the cycle after capture.
module maze_rd_return
    import maze_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   gnt,
    input  logic   we,
    input  owner_e owner,
    input  logic   mem_dout,
    output logic   s_rvalid,
    output logic   s_rdata,
    output logic   h_rvalid,
    output logic   h_rdata,
    output logic   busy
);

    rd_tag_t st0, st1;
    logic    rd_issue;

    assign rd_issue = gnt && !we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st0     <= '0;
            st1     <= '0;
            s_rdata <= 1'b0;
            h_rdata <= 1'b0;
            busy    <= 1'b0;
        end else begin
            st0.valid <= rd_issue;
            st0.owner <= owner;
            st1       <= st0;
            // mem_dout belongs to the read issued last cycle, i.e. the st0 tag
            if (st0.valid) begin
                if (st0.owner == OWN_SOLVER) s_rdata <= mem_dout;
                else                         h_rdata <= mem_dout;
            end
            busy <= rd_issue || st0.valid;
        end
    end

    assign s_rvalid = st1.valid && (st1.owner == OWN_SOLVER);
    assign h_rvalid = st1.valid && (st1.owner == OWN_HOST);

endmodule

// File: rtl/maze_mem_arbiter.sv
// Single-port maze memory arbiter between the solver and host ports.
// Define MAZE_ARB_RR_EN for round-robin arbitration instead of solver priority + starve guard.
module maze_mem_arbiter
    import maze_pkg::*;
#(
    parameter int COORD_W    = COORD_W_DEF,
    parameter int STARVE_MAX = 8
) (
    input  logic                clk,
    input  logic                rst,
    maze_mem_arbiter_if.slave   bus,
    output logic                busy
);

    logic               host_wins;
    logic               s_gnt, h_gnt;
    logic [COORD_W-1:0] cmd_x, cmd_y;
    logic               cmd_rd, cmd_wr, cmd_din;
    owner_e             gnt_owner;

`ifdef MAZE_ARB_RR_EN
    owner_e last_owner;

    assign host_wins = (last_owner == OWN_SOLVER);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        last_owner <= OWN_HOST;
        else if (s_gnt) last_owner <= OWN_SOLVER;
        else if (h_gnt) last_owner <= OWN_HOST;
    end
`else
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
    logic [STARVE_W-1:0] starve;

    assign host_wins = (starve == STARVE_LIM);

    // Counts consecutive denied host cycles; saturates so the host keeps priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      starve <= '0;
        else if (!bus.h_req || h_gnt) starve <= '0;
        else if (starve != STARVE_LIM) starve <= starve + 1'b1;
    end
`endif

    always_comb begin
        s_gnt = 1'b0;
        h_gnt = 1'b0;
        if (!rst) begin
            if (bus.s_req && bus.h_req) begin
                if (host_wins) h_gnt = 1'b1;
                else           s_gnt = 1'b1;
            end else begin
                s_gnt = bus.s_req;
                h_gnt = bus.h_req;
            end
        end
    end

    always_comb begin
        cmd_x   = '0;
        cmd_y   = '0;
        cmd_rd  = 1'b0;
        cmd_wr  = 1'b0;
        cmd_din = 1'b0;
        if (s_gnt) begin
            cmd_x   = bus.s_x;
            cmd_y   = bus.s_y;
            cmd_rd  = !bus.s_we;
            cmd_wr  = bus.s_we;
            cmd_din = bus.s_wdata;
        end else if (h_gnt) begin
            cmd_x   = bus.h_x;
            cmd_y   = bus.h_y;
            cmd_rd  = !bus.h_we;
            cmd_wr  = bus.h_we;
            cmd_din = bus.h_wdata;
        end
    end

    assign bus.s_gnt   = s_gnt;
    assign bus.h_gnt   = h_gnt;
    assign bus.mem_x   = cmd_x;
    assign bus.mem_y   = cmd_y;
    assign bus.mem_rd  = cmd_rd;
    assign bus.mem_wr  = cmd_wr;
    assign bus.mem_din = cmd_din;
    assign gnt_owner   = h_gnt ? OWN_HOST : OWN_SOLVER;

    maze_rd_return u_rd_return (
        .clk      (clk),
        .rst      (rst),
        .gnt      (s_gnt || h_gnt),
        .we       (cmd_wr),
        .owner    (gnt_owner),
        .mem_dout (bus.mem_dout),
        .s_rvalid (bus.s_rvalid),
        .s_rdata  (bus.s_rdata),
        .h_rvalid (bus.h_rvalid),
        .h_rdata  (bus.h_rdata),
        .busy     (busy)
    );

endmodule
